tx_gearbox: RTL and testbench

Transmit gearbox of the 64b/66b PCS, directly downstream of the scrambler. Accepts one scrambled 64-bit payload plus its 2-bit sync header per handshake and emits a continuous 32-bit word stream to the SERDES. It provides backpressure whenever its bit buffer cannot take another 66-bit block, so `in_ready` drives the scrambler's advance (`scrambler_next`). Over any sustained stream it accepts 16 blocks per 33 cycles.

---
 rtl/pcs_pkg.sv | 26 ++
 rtl/tx_gearbox.sv | 103 ++++++++++
 tb/tb_tx_gearbox.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pcs_pkg.sv
// Shared 64b/66b PCS definitions: sync headers, block widths and the block type
// carried from the scrambler into the transmit gearbox.
package pcs_pkg;

  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  localparam int BLK_W     = 66;
  localparam int PAYLOAD_W = 64;

  // Gearbox bit buffer geometry: fill count never exceeds 31 + 66 = 97.
  localparam int GB_BUF_W   = 128;
  localparam int GB_CNT_W   = 7;
  localparam int GB_CNT_MAX = 97;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
  } pcs_blk_t;

  // Only 01 and 10 are legal sync headers; 00 and 11 flag a corrupted block.
  function automatic logic hdr_is_valid(input logic [1:0] hdr);
    return (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);
  endfunction

endpackage

// File: rtl/tx_gearbox.sv
// 66-bit to 32-bit transmit gearbox. Blocks are appended LSB-first into a
// 128-bit buffer; whenever at least one full word is buffered it is emitted
// from bit 0. in_ready depends only on the registered fill count.
module tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DATA_W = 32  // only 32 is supported
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAYLOAD_W-1:0] in_data,
  input  logic [1:0]           in_hdr,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 tx_valid,
  output logic                 hdr_err,
  output logic                 underrun
);

  logic [GB_BUF_W-1:0] sbuf_q, sbuf_d;
  logic [GB_BUF_W-1:0] buf_shift;
  logic [GB_BUF_W-1:0] keep_mask;
  logic [GB_BUF_W-1:0] blk_ext;
  logic [GB_CNT_W-1:0] cnt_q, cnt_d;
  logic [GB_CNT_W-1:0] cnt_shift;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                hdr_err_q, hdr_err_d;
  logic                underrun_q, underrun_d;
  logic                accept;
  pcs_blk_t            blk;

  assign blk      = '{data: in_data, hdr: in_hdr};
  assign blk_ext  = {{(GB_BUF_W-BLK_W){1'b0}}, blk};
  assign in_ready = (cnt_q < 7'd64);
  assign accept   = in_valid && in_ready;

  // Keep only the valid bits below the post-shift fill level so stale bits
  // can never leak into a newly written block.
  genvar gi;
  generate
    for (gi = 0; gi < GB_BUF_W; gi++) begin : g_keep
      assign keep_mask[gi] = (cnt_shift > GB_CNT_W'(gi));
    end
  endgenerate

  // Output step: emit the lowest word and drop it from the buffer when full.
  always_comb begin
    tx_data_d  = '0;
    tx_valid_d = 1'b0;
    buf_shift  = sbuf_q;
    cnt_shift  = cnt_q;
    if (cnt_q >= GB_CNT_W'(DATA_W)) begin
      tx_data_d  = sbuf_q[DATA_W-1:0];
      tx_valid_d = 1'b1;
      buf_shift  = sbuf_q >> DATA_W;
      cnt_shift  = cnt_q - GB_CNT_W'(DATA_W);
    end
  end

  // Insert step: append an accepted block at the post-shift fill level.
  always_comb begin
    sbuf_d     = buf_shift;
    cnt_d      = cnt_shift;
    hdr_err_d  = 1'b0;
    underrun_d = underrun_q | (tx_valid_q & ~tx_valid_d);
    if (accept) begin
      sbuf_d    = (buf_shift & keep_mask) | (blk_ext << cnt_shift);
      cnt_d     = cnt_shift + GB_CNT_W'(BLK_W);
      hdr_err_d = !hdr_is_valid(in_hdr);
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sbuf_q     <= '0;
      cnt_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      hdr_err_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      sbuf_q     <= sbuf_d;
      cnt_q      <= cnt_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      hdr_err_q  <= hdr_err_d;
      underrun_q <= underrun_d;
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign hdr_err  = hdr_err_q;
  assign underrun = underrun_q;

  // Fill level can never exceed 31 leftover bits plus one block.
  a_cnt_bound: assert property (@(posedge clk) disable iff (reset)
    cnt_q <= GB_CNT_W'(GB_CNT_MAX));

endmodule

// File: tb/tb_tx_gearbox.sv
// Directed bench for tx_gearbox: reset, single block, bad header, continuous
// stream with bit-exact reassembly, backpressure pattern, and mid-stream reset.
module tb_tx_gearbox;
  import pcs_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [1:0]  in_hdr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        hdr_err;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  bit          exp_q[$];
  bit          rx_q[$];
  logic [65:0] mon_blk;

  always #5 clk = ~clk;

  tx_gearbox #(.DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_data  (in_data),
    .in_hdr   (in_hdr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .hdr_err  (hdr_err),
    .underrun (underrun)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_random();
    in_data = {$urandom, $urandom};
    in_hdr  = ($urandom_range(0, 1) == 1) ? SYNC_CTRL : SYNC_DATA;
  endtask

  // Mid-cycle monitor: serialise accepted blocks and transmitted words LSB first.
  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) begin
      mon_blk = {in_data, in_hdr};
      for (int i = 0; i < BLK_W; i++) exp_q.push_back(mon_blk[i]);
    end
    if (tx_valid) begin
      for (int i = 0; i < 32; i++) rx_q.push_back(tx_data[i]);
    end
  end

  initial begin
    bit rdy_hist[$];
    int sent, cyc, drops, mism, rdy_cnt, pairs, n;
    bit seen, acc;

    // Reset held with a block offered.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 64'hDEADBEEF_CAFEF00D;
    in_hdr   = SYNC_DATA;
    for (int k = 0; k < 3; k++) begin
      step();
      check_val("rst_tx_valid", tx_valid, 0);
      check_val("rst_tx_data", tx_data, 0);
      check_val("rst_in_ready", in_ready, 1);
      check_val("rst_underrun", underrun, 0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    step();

    // Single block into an empty buffer.
    in_data  = 64'h0123456789ABCDEF;
    in_hdr   = SYNC_DATA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("single_e0_valid", tx_valid, 0);
    check_val("single_e0_hdr_err", hdr_err, 0);
    check_val("single_e0_ready", in_ready, 0);
    step();
    check_val("single_w0", tx_data, 32'h26AF37BD);
    check_val("single_w0_valid", tx_valid, 1);
    check_val("single_e1_ready", in_ready, 1);
    step();
    check_val("single_w1", tx_data, 32'h048D159E);
    check_val("single_w1_valid", tx_valid, 1);
    check_val("single_e2_underrun", underrun, 0);
    step();
    check_val("single_e3_valid", tx_valid, 0);
    check_val("single_e3_data", tx_data, 0);
    check_val("single_e3_underrun", underrun, 1);
    check_val("single_e3_cnt", dut.cnt_q, 2);
    step();
    check_val("single_underrun_sticky", underrun, 1);
    $display("single block: transmitted 26af37bd 048d159e, 2 bits left");

    // Bad header 2'b11.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("bad_underrun_cleared", underrun, 0);
    in_data  = 64'hFEDCBA9876543210;
    in_hdr   = 2'b11;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check_val("bad_hdr_err", hdr_err, 1);
    step();
    check_val("bad_hdr_err_clear", hdr_err, 0);
    check_val("bad_w0", tx_data, 32'hD950C843);
    step();
    check_val("bad_w1", tx_data, 32'hFB72EA61);
    $display("bad header: hdr_err pulsed, payload d950c843 fb72ea61");

    // Continuous stream of 320 blocks from reset.
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    rx_q.delete();
    load_random();
    in_valid = 1'b1;
    sent  = 0;
    cyc   = 0;
    drops = 0;
    seen  = 1'b0;
    while (sent < 320 && cyc < 2000) begin
      acc = in_ready;
      rdy_hist.push_back(in_ready);
      step();
      cyc++;
      if (tx_valid) seen = 1'b1;
      else if (seen) drops++;
      if (acc) begin
        sent++;
        if (sent < 320) load_random();
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check_val("stream_accepts", sent, 320);
    check_val("stream_valid_drops", drops, 0);
    check_val("stream_underrun", underrun, 0);
    n = rdy_hist.size();
    mism = 0;
    for (int k = 0; k + 33 < n; k++) if (rdy_hist[k] != rdy_hist[k+33]) mism++;
    check_val("ready_period", mism, 0);
    rdy_cnt = 0;
    pairs   = 0;
    for (int k = 0; k < 33 && k + 1 < n; k++) begin
      if (rdy_hist[k]) rdy_cnt++;
      if (!rdy_hist[k] && !rdy_hist[k+1]) pairs++;
    end
    check_val("ready_per_period", rdy_cnt, 16);
    check_val("backpressure_pairs", pairs, 1);
    repeat (6) step();
    check_val("stream_exp_bits", exp_q.size(), 320 * 66);
    check_val("stream_rx_bits", rx_q.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      if (exp_q[i] != rx_q[i]) mism++;
    check_val("stream_bits", mism, 0);
    $display("stream: %0d blocks over %0d cycles, %0d bits received", sent, cyc, rx_q.size());

    // Reset in the middle of traffic at c = 68.
    reset = 1'b1;
    step();
    reset = 1'b0;
    load_random();
    in_valid = 1'b1;
    step();            // accept, c = 66
    load_random();
    step();            // no accept, c = 34
    step();            // accept, c = 68
    check_val("mid_cnt68_ready", in_ready, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("mid_rst_valid", tx_valid, 0);
    check_val("mid_rst_ready", in_ready, 1);
    in_data  = 64'h0123456789ABCDEF;
    in_hdr   = SYNC_DATA;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check_val("mid_post_w0", tx_data, 32'h26AF37BD);
    step();
    check_val("mid_post_w1", tx_data, 32'h048D159E);
    $display("mid-stream reset: first post-reset block emitted clean");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
